interrupt_acknowledge_sequencer: RTL and testbench
==================================================

Name: interrupt_acknowledge_sequencer

Overview:
- Sits between the CPU core's interrupt-acknowledge request and the 8259-like interrupt controller.
- Converts one CPU acknowledge request into the two-pulse INTA sequence and holds the bus locked while the sequence runs.
- Captures the vector the controller drives during the second pulse and returns it to the CPU with a one-cycle valid strobe.
- Flags a missing vector response and substitutes a default vector.

Parameters:
- PULSE_WIDTH, 2: clock cycles that each INTA pulse is held low; must be ≥1.
- GAP_WIDTH, 2: clock cycles INTA is held high between the two pulses; must be ≥1.
- DEFAULT_VECTOR, 8'hFF: vector returned when the controller is not driving data at capture.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- cpu_inta_request  in  1  level request from the CPU; held high until vector_valid is seen.
- interrupt_to_cpu  in  1  INT from the controller; informational only, never gates the sequence.
- pic_data_bus_in  in  8  controller data_bus_out.
- pic_data_bus_io  in  1  controller data_bus_io; 0 means the controller is driving data.
- interrupt_acknowledge_n  out  1  INTA strobe to the controller, active-low, registered.
- bus_lock  out  1  high while either pulse or the gap is in progress.
- vector_out  out  8  captured vector; holds its value until the next capture.
- vector_valid  out  1  one-cycle strobe when vector_out updates.
- no_response  out  1  sticky error flag; set when the default vector is substituted.

Behaviour:
- Reset values: interrupt_acknowledge_n=1, bus_lock=0, vector_out=8'h00, vector_valid=0, no_response=0, state=IDLE, counter=0. Reset wins over every other event, including mid-sequence; INTA returns high on that same edge.
- States: IDLE, PULSE1, GAP, PULSE2, DONE, WAIT_RELEASE. A down-counter, sized to hold max(PULSE_WIDTH, GAP_WIDTH), is loaded on each state entry.
- IDLE:
  - INTA_n=1, bus_lock=0.
  - Edge k with cpu_inta_request=1 → PULSE1, counter=PULSE_WIDTH-1, and no_response cleared.
- PULSE1:
  - INTA_n=0, bus_lock=1.
  - Counter decrements each edge; at 0 → GAP with counter=GAP_WIDTH-1.
  - Data is ignored during this pulse.
- GAP:
  - INTA_n=1, bus_lock=1.
  - At counter 0 → PULSE2 with counter=PULSE_WIDTH-1.
- PULSE2:
  - INTA_n=0, bus_lock=1.
  - On the edge where counter=0:
    - If pic_data_bus_io=0: vector_out = pic_data_bus_in.
    - Else: vector_out = DEFAULT_VECTOR and no_response set to 1.
    - Go to DONE.
- DONE:
  - vector_valid=1 for exactly this cycle; INTA_n=1; bus_lock=0.
  - Next edge: → WAIT_RELEASE if the request is still high, else → IDLE.
- WAIT_RELEASE:
  - Outputs idle.
  - → IDLE on the first edge where the request is low.
  - A request held high never starts a second sequence.
- Timing, request first sampled at edge k:
  - INTA_n low on cycles k+1 .. k+PW.
  - INTA_n high on cycles k+PW+1 .. k+PW+GW.
  - INTA_n low on cycles k+PW+GW+1 .. k+2PW+GW.
  - vector_valid on cycle k+2PW+GW+1.
  - Total latency is 2·PW+GW+1 cycles from the sampling edge.
- Request dropping mid-sequence: ignored; the sequence always completes both pulses. The controller requires the pair.
- interrupt_to_cpu dropping mid-sequence: ignored. The controller itself supplies a spurious vector.
- A request rising in the same cycle that reset is high: ignored. The request is sampled on the first edge after reset deasserts.

Test Plan:
- PW=2, GW=2; request high at edge 0; controller drives 8'h08 during the second pulse → INTA_n low on cycles 1–2 and 5–6; bus_lock high on cycles 1–6; vector_valid on cycle 7 with vector_out=8'h08; no_response=0.
- Request held high for 20 cycles after vector_valid → exactly one pulse pair; a second pair appears only after the request goes low for 1 cycle and then high again.
- pic_data_bus_io=1 throughout → vector_out=8'hFF and no_response=1; the next request clears no_response on its sampling edge.
- Reset asserted during GAP → INTA_n=1, bus_lock=0, state IDLE on the next edge; vector_out=8'h00; a subsequent request produces a full two-pulse sequence.
- PW=1, GW=1 build; request → pulses on cycles 1 and 3, vector_valid on cycle 4; the request drops on cycle 2 and both pulses still complete.
- Controller driving 8'hAA during the first pulse and 8'h0D during the second → vector_out=8'h0D.

Source files
------------

// File: rtl/interrupt_acknowledge_sequencer.sv
// Interrupt acknowledge sequencer: turns one CPU acknowledge request into the
// two-pulse INTA sequence, locks the bus while the pulses run, captures the
// controller's vector on the last cycle of the second pulse and returns it
// with a one-cycle valid strobe (default vector + sticky flag on no response).
module interrupt_acknowledge_sequencer #(
    parameter int unsigned PULSE_WIDTH    = 2,
    parameter int unsigned GAP_WIDTH      = 2,
    parameter logic [7:0]  DEFAULT_VECTOR = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_inta_request,
    input  logic       interrupt_to_cpu,
    input  logic [7:0] pic_data_bus_in,
    input  logic       pic_data_bus_io,
    output logic       interrupt_acknowledge_n,
    output logic       bus_lock,
    output logic [7:0] vector_out,
    output logic       vector_valid,
    output logic       no_response
);

    localparam int unsigned MAXW = (PULSE_WIDTH > GAP_WIDTH) ? PULSE_WIDTH : GAP_WIDTH;
    localparam int unsigned CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    localparam logic [CW-1:0] PW_LOAD = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] GW_LOAD = CW'(GAP_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PULSE1,
        GAP,
        PULSE2,
        DONE,
        WAIT_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inta_n_q, inta_n_d;
    logic [7:0]    vector_q, vector_d;
    logic          nr_q, nr_d;

    // INT from the controller is informational only and never gates the sequence.
    logic unused_int;
    assign unused_int = interrupt_to_cpu;

    // State, counter and output registers; reset overrides everything, mid-sequence included.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            inta_n_q <= 1'b1;
            vector_q <= '0;
            nr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_n_q <= inta_n_d;
            vector_q <= vector_d;
            nr_q     <= nr_d;
        end
    end

    // Next-state, counter reload on state entry, vector capture and registered INTA decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vector_d = vector_q;
        nr_d     = nr_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_inta_request) begin
                    state_d = PULSE1;
                    cnt_d   = PW_LOAD;
                    nr_d    = 1'b0;
                end
            end
            PULSE1: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GW_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE2;
                    cnt_d   = PW_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PULSE2: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!pic_data_bus_io) begin
                        vector_d = pic_data_bus_in;
                    end else begin
                        vector_d = DEFAULT_VECTOR;
                        nr_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = cpu_inta_request ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                if (!cpu_inta_request) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // INTA is registered, so it is decoded from the state being entered.
        inta_n_d = !((state_d == PULSE1) || (state_d == PULSE2));
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign bus_lock                = (state_q == PULSE1) || (state_q == GAP) || (state_q == PULSE2);
    assign vector_out              = vector_q;
    assign vector_valid            = (state_q == DONE);
    assign no_response             = nr_q;

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Bench for interrupt_acknowledge_sequencer: a PW=2/GW=2 and a PW=1/GW=1 instance
// share stimulus and are compared against a cycle-offset reference model.
module tb_interrupt_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       req   = 1'b0;
    logic       intr  = 1'b0;
    logic       io    = 1'b1;
    logic [7:0] data  = 8'h00;

    logic       a_inta, a_lock, a_valid, a_nr;
    logic [7:0] a_vec;
    logic       b_inta, b_lock, b_valid, b_nr;
    logic [7:0] b_vec;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int a_falls = 0;
    logic a_prev = 1'b1;

    // Reference model: sequence described as "cycle index since the sampling edge".
    int         pw_of[2] = '{2, 1};
    int         gw_of[2] = '{2, 1};
    bit         m_active[2];
    int         m_c[2];
    bit         m_blk[2];
    logic [7:0] m_vec[2];
    bit         m_nr[2];

    typedef struct {
        bit rst; bit req; bit io; logic [7:0] data;
        bit e_inta; bit e_lock; bit e_valid; logic [7:0] e_vec; bit e_nr;
    } vec_t;
    vec_t tbl[9];

    always #5 clock = ~clock;

    interrupt_acknowledge_sequencer #(
        .PULSE_WIDTH(2), .GAP_WIDTH(2), .DEFAULT_VECTOR(8'hFF)
    ) dut_a (
        .clock(clock), .reset(rst), .cpu_inta_request(req), .interrupt_to_cpu(intr),
        .pic_data_bus_in(data), .pic_data_bus_io(io),
        .interrupt_acknowledge_n(a_inta), .bus_lock(a_lock), .vector_out(a_vec),
        .vector_valid(a_valid), .no_response(a_nr)
    );

    interrupt_acknowledge_sequencer #(
        .PULSE_WIDTH(1), .GAP_WIDTH(1), .DEFAULT_VECTOR(8'hFF)
    ) dut_b (
        .clock(clock), .reset(rst), .cpu_inta_request(req), .interrupt_to_cpu(intr),
        .pic_data_bus_in(data), .pic_data_bus_io(io),
        .interrupt_acknowledge_n(b_inta), .bus_lock(b_lock), .vector_out(b_vec),
        .vector_valid(b_valid), .no_response(b_nr)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input int i);
        int last;
        last = 2 * pw_of[i] + gw_of[i];
        if (rst) begin
            m_active[i] = 0; m_c[i] = 0; m_blk[i] = 0; m_vec[i] = 8'h00; m_nr[i] = 0;
        end else if (m_active[i]) begin
            if (m_c[i] == last) begin
                if (!io) m_vec[i] = data;
                else begin m_vec[i] = 8'hFF; m_nr[i] = 1; end
                m_c[i]++;
            end else if (m_c[i] == last + 1) begin
                m_active[i] = 0;
                m_blk[i]    = req;
            end else begin
                m_c[i]++;
            end
        end else if (m_blk[i]) begin
            if (!req) m_blk[i] = 0;
        end else if (req) begin
            m_active[i] = 1; m_c[i] = 1; m_nr[i] = 0;
        end
    endtask

    task automatic check_models();
        for (int i = 0; i < 2; i++) begin
            int p, g, c;
            bit e_inta, e_lock, e_valid;
            logic inta, lock, valid, nr;
            logic [7:0] vec;
            string pre;
            p = pw_of[i]; g = gw_of[i]; c = m_c[i];
            e_inta  = !(m_active[i] && (c <= p || (c > p + g && c <= 2 * p + g)));
            e_lock  = m_active[i] && (c <= 2 * p + g);
            e_valid = m_active[i] && (c == 2 * p + g + 1);
            if (i == 0) begin
                pre = "A"; inta = a_inta; lock = a_lock; valid = a_valid; nr = a_nr; vec = a_vec;
            end else begin
                pre = "B"; inta = b_inta; lock = b_lock; valid = b_valid; nr = b_nr; vec = b_vec;
            end
            check({pre, ".inta_n"},       8'(inta),  8'(e_inta));
            check({pre, ".bus_lock"},     8'(lock),  8'(e_lock));
            check({pre, ".vector_valid"}, 8'(valid), 8'(e_valid));
            check({pre, ".vector_out"},   vec,       m_vec[i]);
            check({pre, ".no_response"},  8'(nr),    8'(m_nr[i]));
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        cyc++;
        if (a_prev === 1'b1 && a_inta === 1'b0) a_falls++;
        a_prev = a_inta;
        check_models();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // {rst, req, io, data, inta_n, bus_lock, valid, vector, no_response} after each edge (DUT A)
        tbl[0] = '{1, 0, 1, 8'h00, 1, 0, 0, 8'h00, 0};
        tbl[1] = '{0, 1, 1, 8'h00, 0, 1, 0, 8'h00, 0};
        tbl[2] = '{0, 1, 0, 8'hAA, 0, 1, 0, 8'h00, 0};
        tbl[3] = '{0, 1, 0, 8'hAA, 1, 1, 0, 8'h00, 0};
        tbl[4] = '{0, 1, 1, 8'h00, 1, 1, 0, 8'h00, 0};
        tbl[5] = '{0, 1, 0, 8'h08, 0, 1, 0, 8'h00, 0};
        tbl[6] = '{0, 0, 0, 8'h08, 0, 1, 0, 8'h00, 0};
        tbl[7] = '{0, 0, 0, 8'h08, 1, 0, 1, 8'h08, 0};
        tbl[8] = '{0, 0, 1, 8'h00, 1, 0, 0, 8'h08, 0};

        #2;
        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; io = tbl[i].io; data = tbl[i].data;
            step();
            check("tbl.inta_n",       8'(a_inta),  8'(tbl[i].e_inta));
            check("tbl.bus_lock",     8'(a_lock),  8'(tbl[i].e_lock));
            check("tbl.vector_valid", 8'(a_valid), 8'(tbl[i].e_valid));
            check("tbl.vector_out",   a_vec,       tbl[i].e_vec);
            check("tbl.no_response",  8'(a_nr),    8'(tbl[i].e_nr));
        end

        // Held request: one pair only, second pair after a one-cycle release.
        io = 0; data = 8'h21; a_falls = 0;
        req = 1; steps(27);
        check("held.pairs", 8'(a_falls), 8'd2);
        req = 0; step();
        req = 1; steps(8);
        check("rearm.pairs", 8'(a_falls), 8'd4);
        check("rearm.vector", a_vec, 8'h21);
        req = 0; steps(2);

        // No response: default vector and sticky flag, cleared by next sampling edge.
        io = 1; req = 1; steps(7);
        check("noresp.valid",  8'(a_valid), 8'd1);
        check("noresp.vector", a_vec, 8'hFF);
        check("noresp.flag",   8'(a_nr), 8'd1);
        req = 0; steps(2);
        check("noresp.sticky", 8'(a_nr), 8'd1);
        req = 1; step();
        check("noresp.clear",  8'(a_nr), 8'd0);
        io = 0; data = 8'h5A; steps(6);
        check("noresp.next",   a_vec, 8'h5A);
        req = 0; steps(2);

        // Reset during GAP, request already high while reset is asserted.
        req = 1; steps(3);
        check("gap.inta_n", 8'(a_inta), 8'd1);
        check("gap.lock",   8'(a_lock), 8'd1);
        rst = 1; step();
        check("rst.inta_n", 8'(a_inta), 8'd1);
        check("rst.lock",   8'(a_lock), 8'd0);
        check("rst.vector", a_vec, 8'h00);
        check("rst.valid",  8'(a_valid), 8'd0);
        rst = 0; a_falls = 0; data = 8'h33; steps(7);
        check("rst.pairs",  8'(a_falls), 8'd2);
        check("rst.done",   8'(a_valid), 8'd1);
        check("rst.newvec", a_vec, 8'h33);
        req = 0; steps(2);

        // PW=1/GW=1 instance: request drops on cycle 2, both pulses still complete.
        io = 0; data = 8'h0D;
        req = 1; step();
        check("pw1.c1.inta_n", 8'(b_inta), 8'd0);
        req = 0; step();
        check("pw1.c2.inta_n", 8'(b_inta), 8'd1);
        check("pw1.c2.lock",   8'(b_lock), 8'd1);
        step();
        check("pw1.c3.inta_n", 8'(b_inta), 8'd0);
        step();
        check("pw1.c4.valid",  8'(b_valid), 8'd1);
        check("pw1.c4.lock",   8'(b_lock), 8'd0);
        check("pw1.c4.vector", b_vec, 8'h0D);
        steps(4);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            rst  = ($urandom_range(0, 63) == 0);
            io   = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            intr = 1'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
